// File: rtl/strength_pkg.sv
// Shared types and helpers for the strength bus arbiter.
// Optional contention counting is enabled by defining STRENGTH_ARB_CONTENTION_EN.
package strength_pkg;

    localparam int unsigned STR_W  = 3;
    localparam int unsigned HOLD_W = 8;

    typedef enum logic [STR_W-1:0] {
        HIGHZ  = 3'd0,
        WEAK   = 3'd1,
        PULL   = 3'd2,
        STRONG = 3'd3,
        SUPPLY = 3'd4
    } strength_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } arb_state_t;

    // Undefined codes 5..7 behave as an undriven request.
    function automatic strength_t eff_str(input logic [STR_W-1:0] code);
        if (code > 3'd4) begin
            return HIGHZ;
        end
        return strength_t'(code);
    endfunction

endpackage

// File: rtl/strength_rr_pick.sv
// Combinational winner pick: highest strength, round-robin among equal strengths.
module strength_rr_pick
    import strength_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0]       req,
    input  logic [STR_W*N_REQ-1:0] req_str,
    input  logic [N_REQ-1:0]       req_val,
    input  logic [IDX_W-1:0]       rr_ptr,
    output logic [IDX_W-1:0]       win_idx,
    output logic                   win_valid,
    output logic [STR_W-1:0]       win_str,
    output logic                   tie_conflict
);

    logic [STR_W-1:0] s [N_REQ];
    logic [STR_W-1:0] max_str;
    logic             found;
    logic             seen0;
    logic             seen1;
    int               j;

    // Effective strength per requester.
    always_comb begin
        for (int i = 0; i < int'(N_REQ); i++) begin
            s[i] = eff_str(req_str[STR_W*i +: STR_W]);
        end
    end

    // Max strength, first match at/after rr_ptr, and opposite-value tie detection.
    always_comb begin
        max_str = '0;
        win_idx = '0;
        found   = 1'b0;
        seen0   = 1'b0;
        seen1   = 1'b0;
        j       = 0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (req[i] && (s[i] > max_str)) begin
                max_str = s[i];
            end
        end
        for (int k = 0; k < int'(N_REQ); k++) begin
            j = (int'(rr_ptr) + k) % int'(N_REQ);
            if (!found && req[j] && (max_str != '0) && (s[j] == max_str)) begin
                found   = 1'b1;
                win_idx = IDX_W'(j);
            end
        end
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (req[i] && (max_str != '0) && (s[i] == max_str)) begin
                if (req_val[i]) begin
                    seen1 = 1'b1;
                end else begin
                    seen0 = 1'b1;
                end
            end
        end
    end

    assign win_valid    = found;
    assign win_str      = max_str;
    assign tie_conflict = seen0 & seen1;

endmodule

// File: rtl/strength_bus_arbiter.sv
// Shared tri-state net arbiter: strength priority, round-robin ties, bounded hold,
// one-cycle high-Z turnaround. Define STRENGTH_ARB_CONTENTION_EN for the collision counter.
module strength_bus_arbiter
    import strength_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned HOLD_MAX = 15,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [STR_W*N_REQ-1:0] req_str,
    input  logic [N_REQ-1:0]       req_val,
    output logic [N_REQ-1:0]       gnt,
    output logic                   bus_val,
    output logic [STR_W-1:0]       bus_str,
    output logic                   busy,
    output logic [CNT_W-1:0]       contention_cnt
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [IDX_W-1:0]  own_q, own_d;
    logic [N_REQ-1:0]  gnt_d;
    logic              bus_val_d;
    logic [STR_W-1:0]  bus_str_d;
    logic              busy_d;

    logic [IDX_W-1:0]  win_idx;
    logic              win_valid;
    logic [STR_W-1:0]  win_str;
    logic              tie_conflict;

    logic              own_req;
    logic              own_val;
    logic [STR_W-1:0]  own_str;
    logic              release_own;

    strength_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req          (req),
        .req_str      (req_str),
        .req_val      (req_val),
        .rr_ptr       (rr_q),
        .win_idx      (win_idx),
        .win_valid    (win_valid),
        .win_str      (win_str),
        .tie_conflict (tie_conflict)
    );

    // Current grantee's live request, value and effective strength.
    always_comb begin
        own_req = 1'b0;
        own_val = 1'b0;
        own_str = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (IDX_W'(i) == own_q) begin
                own_req = req[i];
                own_val = req_val[i];
                own_str = eff_str(req_str[STR_W*i +: STR_W]);
            end
        end
    end

    assign release_own = !own_req || (own_str == '0) ||
                         (hold_q == HOLD_W'(HOLD_MAX)) ||
                         (win_valid && (win_str > own_str));

    // Next-state and registered-output values.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        rr_d      = rr_q;
        own_d     = own_q;
        gnt_d     = gnt;
        bus_val_d = bus_val;
        bus_str_d = bus_str;
        busy_d    = busy;
        unique case (state_q)
            ST_IDLE, ST_TURN: begin
                if (win_valid) begin
                    state_d   = ST_OWN;
                    gnt_d     = N_REQ'(1) << win_idx;
                    bus_val_d = req_val[win_idx];
                    bus_str_d = win_str;
                    busy_d    = 1'b1;
                    hold_d    = HOLD_W'(1);
                    own_d     = win_idx;
                end else begin
                    state_d   = ST_IDLE;
                    gnt_d     = '0;
                    bus_val_d = 1'b0;
                    bus_str_d = '0;
                    busy_d    = 1'b0;
                    hold_d    = '0;
                end
            end
            ST_OWN: begin
                if (release_own) begin
                    state_d   = ST_TURN;
                    gnt_d     = '0;
                    bus_val_d = 1'b0;
                    bus_str_d = '0;
                    busy_d    = 1'b1;
                    hold_d    = '0;
                    rr_d      = (own_q == IDX_W'(N_REQ - 1)) ? '0 : own_q + 1'b1;
                end else begin
                    bus_val_d = own_val;
                    bus_str_d = own_str;
                    hold_d    = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            rr_q    <= '0;
            own_q   <= '0;
            gnt     <= '0;
            bus_val <= 1'b0;
            bus_str <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rr_q    <= rr_d;
            own_q   <= own_d;
            gnt     <= gnt_d;
            bus_val <= bus_val_d;
            bus_str <= bus_str_d;
            busy    <= busy_d;
        end
    end

`ifdef STRENGTH_ARB_CONTENTION_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating count of opposite-value ties at the winning strength.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if ((state_q != ST_OWN) && tie_conflict && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign contention_cnt = cnt_q;
`else
    logic unused_tie;
    assign unused_tie     = tie_conflict;
    assign contention_cnt = '0;
`endif

endmodule
